// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between video refresh,
// CPU bus cycles and disk-copy DMA. Accesses are serialised with fixed
// priority (video > CPU > DMA); an aging counter lets a starved DMA
// requester outrank the CPU once after DMA_MAX_WAIT lost rounds.
// Every access runs IDLE -> BUSY -> GAP, so back-to-back accesses with an
// immediate mem_ack complete at one per three cycles.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned AW           = 25,
  parameter int unsigned DMA_MAX_WAIT = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,

  // video refresh fetch (read only)
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_data,

  // CPU bus cycles
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  output logic [15:0]   cpu_dout,
  output logic          cpu_ack,

  // disk-copy DMA
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_din,
  output logic [15:0]   dma_dout,
  output logic          dma_ack,

  // main-memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ack,

  // current owner: 0 none, 1 video, 2 CPU, 3 DMA
  output logic [1:0]    grant
);

  localparam int unsigned AGE_W = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_VID  = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_DMA  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [AGE_W-1:0] age;
  logic             age_full_c;
  logic [1:0]       win_c;

  // DMA has lost enough rounds to outrank the CPU on the next decision
  assign age_full_c = (age == AGE_W'(DMA_MAX_WAIT));

  // Winner of the current arbitration round; only consumed in IDLE
  always_comb begin
    win_c = G_NONE;
    if (vid_req) begin
      win_c = G_VID;
    end else if (dma_req && (age_full_c || !cpu_req)) begin
      win_c = G_DMA;
    end else if (cpu_req) begin
      win_c = G_CPU;
    end
  end

  // Arbitration FSM with registered memory-port and requester outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      age      <= '0;
      grant    <= G_NONE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= 2'b00;
      mem_addr <= '0;
      mem_din  <= 16'h0000;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      vid_data <= 16'h0000;
      cpu_dout <= 16'h0000;
      dma_dout <= 16'h0000;
    end else begin
      // acks are single-cycle pulses raised only on the BUSY -> GAP edge
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      case (state)
        S_IDLE: begin
          if (win_c != G_NONE) begin
            state   <= S_BUSY;
            grant   <= win_c;
            mem_req <= 1'b1;
            case (win_c)
              G_VID: begin
                mem_addr <= vid_addr;
                mem_we   <= 1'b0;
                mem_be   <= 2'b11;
                mem_din  <= 16'h0000;
              end
              G_CPU: begin
                mem_addr <= cpu_addr;
                mem_we   <= cpu_we;
                // byte enables only qualify writes; reads fetch the full word
                mem_be   <= cpu_we ? cpu_be : 2'b11;
                mem_din  <= cpu_din;
              end
              default: begin
                mem_addr <= dma_addr;
                mem_we   <= dma_we;
                mem_be   <= 2'b11;
                mem_din  <= dma_din;
              end
            endcase
          end

          // age counts decisions DMA wanted but lost, saturating at the limit
          if (dma_req && (win_c != G_DMA)) begin
            if (!age_full_c) begin
              age <= age + AGE_W'(1);
            end
          end else begin
            age <= '0;
          end
        end

        S_BUSY: begin
          if (mem_ack) begin
            state   <= S_GAP;
            mem_req <= 1'b0;
            case (grant)
              G_VID: begin
                vid_data <= mem_dout;
                vid_ack  <= 1'b1;
              end
              G_CPU: begin
                if (!mem_we) begin
                  cpu_dout <= mem_dout;
                end
                cpu_ack <= 1'b1;
              end
              G_DMA: begin
                if (!mem_we) begin
                  dma_dout <= mem_dout;
                end
                dma_ack <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end

        S_GAP: begin
          state <= S_IDLE;
          grant <= G_NONE;
        end

        default: begin
          state <= S_IDLE;
          grant <= G_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int unsigned AW = 25;
  localparam int MAXW = 8;

  logic          clk_sys;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [15:0]   vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [15:0]   cpu_dout;
  logic          cpu_ack;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_din;
  logic [15:0]   dma_dout;
  logic          dma_ack;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;
  logic          mem_ack;
  logic [1:0]    grant;

  mem_arbiter #(.AW(AW), .DMA_MAX_WAIT(MAXW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vid_req (vid_req),
    .vid_addr(vid_addr),
    .vid_ack (vid_ack),
    .vid_data(vid_data),
    .cpu_req (cpu_req),
    .cpu_we  (cpu_we),
    .cpu_be  (cpu_be),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_ack (cpu_ack),
    .dma_req (dma_req),
    .dma_we  (dma_we),
    .dma_addr(dma_addr),
    .dma_din (dma_din),
    .dma_dout(dma_dout),
    .dma_ack (dma_ack),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_be  (mem_be),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_dout(mem_dout),
    .mem_ack (mem_ack),
    .grant   (grant)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester side: index 1 video, 2 CPU, 3 DMA (same as grant encoding)
  bit            rq     [1:3];
  bit            r_we   [1:3];
  logic [1:0]    r_be   [1:3];
  logic [AW-1:0] r_addr [1:3];
  logic [15:0]   r_din  [1:3];
  bit            done   [1:3];

  // transaction-level model
  int            phase;      // 0 free to arbitrate, 1 memory access open, 2 completion cycle
  int            owner;
  int            m_age;
  int            busy_cnt;
  int            lat;
  int            lat_fix;
  bit            spur_en;
  bit            dat_fix_en;
  logic [15:0]   dat_fix;
  logic [AW-1:0] own_addr;
  bit            own_we;
  logic [1:0]    own_be;
  logic [15:0]   own_din;
  bit            exp_req;
  int            exp_grant;
  bit            exp_ack [1:3];
  logic [15:0]   m_dout  [1:3];

  task automatic new_req(input int i);
    rq[i]     = 1'b1;
    r_we[i]   = 1'($urandom_range(0, 1));
    r_be[i]   = 2'($urandom_range(0, 3));
    r_addr[i] = AW'($urandom);
    r_din[i]  = 16'($urandom);
  endtask

  // video first; CPU and DMA swap ranks once DMA has waited out its budget
  function automatic int pick();
    int order[3];
    if (m_age == MAXW) order = '{1, 3, 2};
    else               order = '{1, 2, 3};
    for (int k = 0; k < 3; k++) begin
      if (rq[order[k]]) return order[k];
    end
    return 0;
  endfunction

  // drive one cycle of stimulus, predict the next cycle, then check it
  task automatic tick();
    int w;
    vid_req  = rq[1];
    vid_addr = r_addr[1];
    cpu_req  = rq[2];
    cpu_we   = r_we[2];
    cpu_be   = r_be[2];
    cpu_addr = r_addr[2];
    cpu_din  = r_din[2];
    dma_req  = rq[3];
    dma_we   = r_we[3];
    dma_addr = r_addr[3];
    dma_din  = r_din[3];
    mem_ack  = 1'b0;
    mem_dout = 16'($urandom);
    for (int i = 1; i <= 3; i++) exp_ack[i] = 1'b0;

    case (phase)
      0: begin
        w = pick();
        if (spur_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
        if (rq[3] && w != 3) m_age = (m_age < MAXW) ? m_age + 1 : MAXW;
        else                 m_age = 0;
        if (w != 0) begin
          owner     = w;
          own_addr  = r_addr[w];
          own_we    = (w == 1) ? 1'b0 : r_we[w];
          own_be    = (w == 2 && own_we) ? r_be[2] : 2'b11;
          own_din   = r_din[w];
          busy_cnt  = 0;
          lat       = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
          phase     = 1;
          exp_req   = 1'b1;
          exp_grant = w;
        end else begin
          exp_req   = 1'b0;
          exp_grant = 0;
        end
      end
      1: begin
        if (busy_cnt == lat) begin
          mem_ack = 1'b1;
          if (dat_fix_en) mem_dout = dat_fix;
          if (!own_we) m_dout[owner] = mem_dout;
          exp_ack[owner] = 1'b1;
          exp_req   = 1'b0;
          exp_grant = owner;
          phase     = 2;
        end else begin
          busy_cnt++;
          exp_req   = 1'b1;
          exp_grant = owner;
        end
      end
      default: begin
        if (spur_en && $urandom_range(0, 1) == 0) mem_ack = 1'b1;
        done[owner] = 1'b1;
        owner     = 0;
        phase     = 0;
        exp_req   = 1'b0;
        exp_grant = 0;
      end
    endcase

    @(posedge clk_sys);
    #1;
    chk("grant",    32'(grant),    32'(exp_grant));
    chk("mem_req",  32'(mem_req),  32'(exp_req));
    chk("vid_ack",  32'(vid_ack),  32'(exp_ack[1]));
    chk("cpu_ack",  32'(cpu_ack),  32'(exp_ack[2]));
    chk("dma_ack",  32'(dma_ack),  32'(exp_ack[3]));
    chk("vid_data", 32'(vid_data), 32'(m_dout[1]));
    chk("cpu_dout", 32'(cpu_dout), 32'(m_dout[2]));
    chk("dma_dout", 32'(dma_dout), 32'(m_dout[3]));
    if (exp_req) begin
      chk("mem_addr", 32'(mem_addr), 32'(own_addr));
      chk("mem_we",   32'(mem_we),   32'(own_we));
      chk("mem_be",   32'(mem_be),   32'(own_be));
      if (own_we) chk("mem_din", 32'(mem_din), 32'(own_din));
    end
  endtask

  // directed requesters withdraw once their access has completed
  task automatic tick_drop();
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (done[i]) begin
        done[i] = 1'b0;
        rq[i]   = 1'b0;
      end
    end
  endtask

  function automatic int rate(input int i);
    return (i == 1) ? 15 : ((i == 2) ? 60 : 40);
  endfunction

  // random requester behaviour obeying the hold-until-ack protocol
  task automatic rand_reqs();
    for (int i = 1; i <= 3; i++) begin
      if (done[i]) begin
        done[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) new_req(i);
        else rq[i] = 1'b0;
      end else if (!rq[i] && owner != i) begin
        if (int'($urandom_range(0, 99)) < rate(i)) new_req(i);
      end else if (rq[i] && owner == i && phase == 1) begin
        if ($urandom_range(0, 99) < 5) rq[i] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    phase = 0;
    owner = 0;
    m_age = 0;
    for (int i = 1; i <= 3; i++) begin
      m_dout[i] = 16'h0000;
      done[i]   = 1'b0;
    end
  endtask

  initial begin
    int t_v;
    int t_c;
    int n_ack;
    int ew;
    bit prev;
    logic [15:0] keep;

    n_chk = 0;
    n_err = 0;
    for (int i = 1; i <= 3; i++) begin
      rq[i] = 1'b0; r_we[i] = 1'b0; r_be[i] = 2'b00;
      r_addr[i] = '0; r_din[i] = 16'h0000;
    end
    model_reset();
    lat_fix = -1; spur_en = 1'b0; dat_fix_en = 1'b0; dat_fix = 16'h0000;
    vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_be = 0;
    cpu_addr = '0; cpu_din = 0; dma_req = 0; dma_we = 0; dma_addr = '0;
    dma_din = 0; mem_dout = 0; mem_ack = 0;

    // reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_be",   32'(mem_be),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din",  32'(mem_din),  32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_acks",     32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
    chk("rst_douts",    32'({vid_data, cpu_dout}), 32'd0);
    chk("rst_dma_dout", 32'(dma_dout), 32'd0);
    reset_n = 1'b1;
    tick();

    // single CPU read, mem_ack on the second mem_req cycle
    rq[2] = 1'b1; r_we[2] = 1'b0; r_be[2] = 2'b01; r_addr[2] = AW'(32'h00123);
    lat_fix = 1; dat_fix_en = 1'b1; dat_fix = 16'hBEEF;
    tick_drop();
    tick_drop();
    tick_drop();
    chk("rd_cpu_ack",  32'(cpu_ack),  32'd1);
    chk("rd_cpu_dout", 32'(cpu_dout), 32'hBEEF);
    chk("rd_grant",    32'(grant),    32'd2);
    tick_drop();
    chk("rd_grant_end", 32'(grant), 32'd0);
    dat_fix_en = 1'b0;
    tick_drop();

    // video and CPU together: video first, CPU three cycles later
    lat_fix = 0;
    new_req(1);
    new_req(2); r_we[2] = 1'b0;
    t_v = -1; t_c = -1; prev = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick_drop();
      if (mem_req && !prev) begin
        if (grant == 2'd1 && t_v < 0) t_v = c;
        else if (grant == 2'd2 && t_c < 0) t_c = c;
      end
      prev = mem_req;
    end
    chk("pri_vid_first", 32'(t_v), 32'd0);
    chk("pri_cpu_delay", 32'(t_c - t_v), 32'd3);

    // aging: CPU and DMA held, DMA wins after MAXW lost rounds
    new_req(2); r_we[2] = 1'b0;
    new_req(3); r_we[3] = 1'b0;
    for (int r = 0; r < 20; r++) begin
      if (r == 17) new_req(1);
      ew = (r == 8 || r == 18) ? 3 : ((r == 17) ? 1 : 2);
      for (int s = 0; s < 3; s++) begin
        tick();
        if (s == 0) chk("age_round_winner", 32'(grant), 32'(ew));
        done[2] = 1'b0;
        done[3] = 1'b0;
        if (done[1]) begin
          done[1] = 1'b0;
          rq[1]   = 1'b0;
        end
      end
    end
    rq[2] = 1'b0; rq[3] = 1'b0;
    tick_drop();

    // CPU byte write
    keep = m_dout[2];
    rq[2] = 1'b1; r_we[2] = 1'b1; r_be[2] = 2'b10; r_din[2] = 16'h5A00;
    r_addr[2] = AW'($urandom);
    lat_fix = 1;
    tick_drop();
    chk("wr_mem_we",  32'(mem_we),  32'd1);
    chk("wr_mem_be",  32'(mem_be),  32'b10);
    chk("wr_mem_din", 32'(mem_din), 32'h5A00);
    repeat (4) tick_drop();
    chk("wr_dout_kept", 32'(cpu_dout), 32'(keep));

    // reset pulse during a DMA read, CPU waiting behind it
    new_req(3); r_we[3] = 1'b0;
    lat_fix = 3;
    tick_drop();
    new_req(2); r_we[2] = 1'b0;
    tick_drop();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_grant",   32'(grant),   32'd0);
    chk("arst_dma_ack", 32'(dma_ack), 32'd0);
    model_reset();
    rq[3] = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("arst_held_ack", 32'(dma_ack), 32'd0);
    reset_n = 1'b1;
    lat_fix = 0;
    tick_drop();
    chk("arst_regrant_cpu", 32'(grant), 32'd2);
    repeat (3) tick_drop();

    // CPU drops its request one cycle into BUSY
    new_req(2); r_we[2] = 1'b0;
    lat_fix = 2;
    n_ack = 0;
    tick_drop();
    tick_drop();
    rq[2] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick_drop();
      if (cpu_ack) n_ack++;
    end
    chk("drop_ack_count", 32'(n_ack), 32'd1);

    // randomized traffic with random memory latency and stray mem_ack
    lat_fix = -1;
    spur_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rand_reqs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between three requesters: video refresh fetch, CPU bus cycles, and disk-copy DMA (the dsk_copy path).
- Sits between the CPU/video/disk blocks and the memory block.
- Serialises accesses with fixed priority. An aging counter keeps DMA from starving behind a busy CPU.

Parameters:
- AW, 25, address width in words for all ports.
- DMA_MAX_WAIT, 8, number of lost arbitration rounds after which DMA outranks CPU once.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request (level).
- vid_addr  in  AW  video word address.
- vid_ack  out  1  one-cycle pulse; vid_data valid this cycle.
- vid_data  out  16  read data for video.
- cpu_req  in  1  CPU request (level).
- cpu_we  in  1  1 = write.
- cpu_be  in  2  byte enables for writes.
- cpu_addr  in  AW  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req  in  1  DMA request (level).
- dma_we  in  1  1 = write.
- dma_addr  in  AW  DMA word address.
- dma_din  in  16  DMA write data.
- dma_dout  out  16  DMA read data.
- dma_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_be  out  2  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_din  out  16  memory write data.
- mem_dout  in  16  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- grant  out  2  current owner: 0 = none, 1 = video, 2 = CPU, 3 = DMA.

Behaviour:
- Reset (async, reset_n = 0): state = IDLE. All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_din, all acks, all dout registers, grant. Aging counter = 0.
- Requester protocol: hold req and all request fields stable until the ack pulse. On the cycle after ack, either drop req or present a new request.
- States:
  - IDLE: if any req is high, choose a winner, register its addr/we/be/din into mem_* outputs, set grant, assert mem_req next cycle, go to BUSY. With no req, stay in IDLE.
  - BUSY: hold mem_req and all mem_* fields constant. When mem_ack is high (legal from the first BUSY cycle): register mem_dout into the winner's dout register, pulse the winner's ack next cycle, drop mem_req next cycle, go to GAP.
  - GAP: one cycle. Winner's ack = 1 here. mem_req = 0, grant retained. Next state IDLE, grant -> 0.
- Latency: req rises in cycle 0 (IDLE) -> mem_req = 1 in cycle 1 -> mem_ack in cycle N (N >= 1) -> ack in cycle N+1. Minimum 2 cycles; back-to-back throughput is one access per 3 cycles when mem_ack is immediate.
- Priority: video > CPU > DMA.
  - Exception: if age == DMA_MAX_WAIT and dma_req is high, DMA beats CPU (never video).
  - age increments once per IDLE decision in which dma_req is high but DMA loses, saturating at DMA_MAX_WAIT. It clears when DMA is granted or when dma_req is low at a decision.
- Video accesses force mem_we = 0 and mem_be = 2'b11. DMA accesses force mem_be = 2'b11. CPU accesses pass cpu_be through; cpu_be is ignored for reads, where mem_be = 2'b11.
- dout registers hold their value until the owner's next read completes. A write completion leaves the corresponding dout unchanged.
- Requester drops req mid-transaction: the memory cycle still completes and the ack still pulses. Next arbitration ignores the dropped requester.
- Simultaneous events: a request arriving during BUSY or GAP waits for IDLE. Requests are evaluated only in IDLE.
- mem_ack while not BUSY: ignored.
- Reset mid-BUSY: mem_req drops asynchronously, and no ack is issued for the aborted access.

Test Plan:
- Single CPU read, addr 0x00123, mem_ack 2 cycles after mem_req -> mem_req high 2 cycles; cpu_ack in cycle 3 with cpu_dout = mem_dout (0xBEEF); grant sequence 2, 2, 2, 0.
- vid_req and cpu_req raised in the same cycle -> video served first (grant = 1), CPU next; CPU mem_req rises 3 cycles after the video mem_req with immediate mem_ack.
- cpu_req held continuously (re-requesting every IDLE) plus dma_req high, DMA_MAX_WAIT = 8 -> CPU wins 8 rounds, DMA wins the 9th, age back to 0; video injected in that round still wins.
- CPU byte write cpu_be = 2'b10, din 0x5A00 -> mem_we = 1, mem_be = 2'b10, mem_din = 0x5A00; cpu_dout unchanged.
- reset_n pulsed low during BUSY of a DMA read -> mem_req = 0 immediately, no dma_ack, grant = 0; after release, pending cpu_req is granted normally.
- cpu_req dropped one cycle into BUSY -> cpu_ack still pulses once; no second CPU access follows.
